// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared constants and enums for the CPU data-bus responder
package cpu_bus_pkg;

   // Word offsets inside the I/O window (low 16 address bits)
   localparam logic [15:0] IO_LED     = 16'h0000;
   localparam logic [15:0] IO_COUNTER = 16'h0004;
   localparam logic [15:0] IO_STATUS  = 16'h0008;

   typedef enum logic {IDLE, WAIT} state_t;

   typedef enum logic [1:0] {RAM, IO, UNMAPPED} region_t;

endpackage

// File: rtl/cpu_data_ram.sv
// rtl/cpu_data_ram.sv - single-port byte-enabled data RAM with one-cycle read
module cpu_data_ram #(
   parameter int ADDR_BITS = 14
) (
   input  logic                 clock,
   input  logic                 en,
   input  logic                 we,
   input  logic [3:0]           wstrb,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

   // Byte-masked write; read output only updates on a read so it holds across wait cycles
   always_ff @(posedge clock) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (wstrb[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/cpu_data_responder.sv
// rtl/cpu_data_responder.sv - CPU data-bus target: RAM, I/O registers, read latency control
module cpu_data_responder #(
   parameter int          RAM_ADDR_BITS = 14,
   parameter int          READ_LATENCY  = 1,
   parameter logic [31:0] IO_BASE       = 32'hE000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_request,
   input  logic [31:0] cpu_address,
   input  logic        cpu_write,
   input  logic [3:0]  cpu_wstrb,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_mem_busy,
   output logic        cpu_valid,
   output logic [31:0] led_out,
   output logic        bus_error
);

   import cpu_bus_pkg::*;

   logic        accept;
   region_t     region;
   logic [15:0] io_offset;
   logic [31:0] io_rdata;
   logic [31:0] cycle_count;
   logic [31:0] ram_rdata;
   state_t      state;
   logic [2:0]  wait_count;
   region_t     rd_region_q;
   logic [31:0] io_rdata_q;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^cpu_address[1:0];
   assign accept           = cpu_request & ~cpu_mem_busy;
   assign io_offset        = {cpu_address[15:2], 2'b00};

   // Region decode: RAM at the bottom of the map, I/O window on the upper halfword
   always_comb begin
      region = UNMAPPED;
      if (cpu_address[31:RAM_ADDR_BITS+2] == '0) begin
         region = RAM;
      end else if (cpu_address[31:16] == IO_BASE[31:16]) begin
         region = IO;
      end
   end

   // I/O read mux; unlisted offsets read as zero
   always_comb begin
      io_rdata = 32'h0;
      case (io_offset)
         IO_LED:     io_rdata = led_out;
         IO_COUNTER: io_rdata = cycle_count;
         IO_STATUS:  io_rdata = {31'h0, bus_error};
         default:    io_rdata = 32'h0;
      endcase
   end

   cpu_data_ram #(.ADDR_BITS(RAM_ADDR_BITS)) u_ram (
      .clock (clock),
      .en    (accept && (region == RAM)),
      .we    (cpu_write),
      .wstrb (cpu_wstrb),
      .addr  (cpu_address[RAM_ADDR_BITS+1:2]),
      .wdata (cpu_wdata),
      .rdata (ram_rdata)
   );

   // Free-running cycle counter, wraps naturally
   always_ff @(posedge clock) begin
      if (!reset) begin
         cycle_count <= 32'h0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
      end
   end

   // LED register writes and sticky bus-error flag
   always_ff @(posedge clock) begin
      if (!reset) begin
         led_out   <= 32'h0;
         bus_error <= 1'b0;
      end else if (accept) begin
         if (region == UNMAPPED) begin
            bus_error <= 1'b1;
         end else if (region == IO && cpu_write) begin
            if (io_offset == IO_LED) begin
               for (int i = 0; i < 4; i++) begin
                  if (cpu_wstrb[i]) begin
                     led_out[8*i +: 8] <= cpu_wdata[8*i +: 8];
                  end
               end
            end else if (io_offset == IO_STATUS && cpu_wstrb[0] && cpu_wdata[0]) begin
               bus_error <= 1'b0;
            end
         end
      end
   end

   // Capture the source of an accepted read; I/O values are sampled at acceptance
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_region_q <= UNMAPPED;
         io_rdata_q  <= 32'h0;
      end else if (accept && !cpu_write) begin
         rd_region_q <= region;
         io_rdata_q  <= (region == IO) ? io_rdata : 32'h0;
      end
   end

   // Read-latency FSM: holds off new requests while a slow read is in flight
   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         wait_count   <= 3'd0;
         cpu_mem_busy <= 1'b0;
         cpu_valid    <= 1'b0;
      end else begin
         cpu_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && !cpu_write) begin
                  if (READ_LATENCY == 1) begin
                     cpu_valid <= 1'b1;
                  end else begin
                     state        <= WAIT;
                     wait_count   <= 3'(READ_LATENCY - 1);
                     cpu_mem_busy <= 1'b1;
                  end
               end
            end
            WAIT: begin
               wait_count <= wait_count - 3'd1;
               if (wait_count == 3'd1) begin
                  state        <= IDLE;
                  cpu_mem_busy <= 1'b0;
                  cpu_valid    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data is forced to zero outside the valid pulse
   assign cpu_rdata = !cpu_valid ? 32'h0 : ((rd_region_q == RAM) ? ram_rdata : io_rdata_q);

endmodule

// File: tb/tb_cpu_data_responder.sv
// tb/tb_cpu_data_responder.sv - bench for cpu_data_responder at read latencies 1 and 3
module tb_cpu_data_responder;

   logic        clock = 1'b0;
   int          cyc = 0;
   logic        resetn [2];
   logic        req    [2];
   logic        wr     [2];
   logic [31:0] addr   [2];
   logic [3:0]  strb   [2];
   logic [31:0] wd     [2];
   logic [31:0] rdata  [2];
   logic        busy   [2];
   logic        valid  [2];
   logic [31:0] led    [2];
   logic        berr   [2];

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [int];
   logic [31:0] led_m [2];
   logic        berr_m [2];
   logic        cnt_have [2];
   logic [31:0] cnt_val [2];
   int          cnt_cyc [2];

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   cpu_data_responder #(.RAM_ADDR_BITS(14), .READ_LATENCY(1), .IO_BASE(32'hE000_0000)) u_lat1 (
      .clock(clock), .reset(resetn[0]), .cpu_request(req[0]), .cpu_address(addr[0]),
      .cpu_write(wr[0]), .cpu_wstrb(strb[0]), .cpu_wdata(wd[0]), .cpu_rdata(rdata[0]),
      .cpu_mem_busy(busy[0]), .cpu_valid(valid[0]), .led_out(led[0]), .bus_error(berr[0])
   );

   cpu_data_responder #(.RAM_ADDR_BITS(14), .READ_LATENCY(3), .IO_BASE(32'hE000_0000)) u_lat3 (
      .clock(clock), .reset(resetn[1]), .cpu_request(req[1]), .cpu_address(addr[1]),
      .cpu_write(wr[1]), .cpu_wstrb(strb[1]), .cpu_wdata(wd[1]), .cpu_rdata(rdata[1]),
      .cpu_mem_busy(busy[1]), .cpu_valid(valid[1]), .led_out(led[1]), .bus_error(berr[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int s);
      req[s] = 1'b0; wr[s] = 1'b0; addr[s] = 32'h0; strb[s] = 4'h0; wd[s] = 32'h0;
   endtask

   task automatic drive(input int s, input logic w, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] d);
      req[s] = 1'b1; wr[s] = w; addr[s] = a; strb[s] = st; wd[s] = d;
   endtask

   function automatic int region_of(input logic [31:0] a);
      if (a < 32'h0001_0000) return 0;
      if (a[31:16] == 16'hE000) return 1;
      return 2;
   endfunction

   function automatic int key(input int s, input logic [31:0] a);
      return s * 32'h0010_0000 + int'(a[15:2]);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] st,
                                         input logic [31:0] d);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // One complete bus transaction; checks acceptance, busy, valid timing and zero rdata
   task automatic access(input int s, input logic w, input logic [31:0] a, input logic [3:0] st,
                         input logic [31:0] d, output logic [31:0] rd, output int acc);
      int n;
      int lat;
      lat = (s == 0) ? 1 : 3;
      rd  = 32'h0;
      @(negedge clock);
      drive(s, w, a, st, d);
      n = 0;
      while (busy[s] && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("accept_timeout", 32'(n < 20), 32'd1);
      acc = cyc;
      @(posedge clock);
      @(negedge clock);
      idle(s);
      if (w) begin
         chk("wr_no_valid", 32'(valid[s]), 32'd0);
         chk("wr_no_busy", 32'(busy[s]), 32'd0);
      end else begin
         for (int k = 1; k <= lat + 1; k++) begin
            if (k > 1) @(negedge clock);
            if (k == lat) begin
               chk("rd_valid", 32'(valid[s]), 32'd1);
               rd = rdata[s];
            end else begin
               chk("rd_no_valid", 32'(valid[s]), 32'd0);
               chk("rd_zero", rdata[s], 32'h0);
            end
            chk("rd_busy", 32'(busy[s]), (k < lat) ? 32'd1 : 32'd0);
         end
      end
   endtask

   // Transaction plus reference-model update and result comparison
   task automatic do_op(input int s, input logic w, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] d);
      logic [31:0] exp;
      logic [31:0] rd;
      logic [31:0] old;
      int acc;
      int rg;
      int off;
      rg  = region_of(a);
      off = int'(a[15:0]) & 32'hFFFC;
      exp = 32'h0;
      if (!w) begin
         if (rg == 0) exp = mem_m[key(s, a)];
         else if (rg == 1 && off == 0) exp = led_m[s];
         else if (rg == 1 && off == 8) exp = {31'h0, berr_m[s]};
      end
      access(s, w, a, st, d, rd, acc);
      if (rg == 2) begin
         berr_m[s] = 1'b1;
      end else if (w && rg == 0) begin
         old = mem_m.exists(key(s, a)) ? mem_m[key(s, a)] : 32'h0;
         mem_m[key(s, a)] = merge(old, st, d);
      end else if (w && rg == 1) begin
         if (off == 0) led_m[s] = merge(led_m[s], st, d);
         else if (off == 8 && st[0] && d[0]) berr_m[s] = 1'b0;
      end
      if (!w) begin
         if (rg == 1 && off == 4) begin
            if (cnt_have[s]) begin
               chk("counter", rd, cnt_val[s] + 32'(acc - cnt_cyc[s]));
            end else begin
               cnt_have[s] = 1'b1;
               cnt_val[s]  = rd;
               cnt_cyc[s]  = acc;
            end
         end else begin
            chk("rdata", rd, exp);
         end
      end
      chk("led_out", led[s], led_m[s]);
      chk("bus_error", 32'(berr[s]), 32'(berr_m[s]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  st;
      logic        w;
      int          r;

      for (int s = 0; s < 2; s++) begin
         idle(s);
         resetn[s]   = 1'b0;
         led_m[s]    = 32'h0;
         berr_m[s]   = 1'b0;
         cnt_have[s] = 1'b0;
      end

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      for (int s = 0; s < 2; s++) begin
         chk("rst_valid", 32'(valid[s]), 32'd0);
         chk("rst_busy", 32'(busy[s]), 32'd0);
         chk("rst_rdata", rdata[s], 32'h0);
         chk("rst_led", led[s], 32'h0);
         chk("rst_berr", 32'(berr[s]), 32'd0);
      end
      resetn[0] = 1'b1;
      resetn[1] = 1'b1;

      // Write then read, latency 1
      do_op(0, 1'b1, 32'h100, 4'hF, 32'h1234_5678);
      do_op(0, 1'b0, 32'h100, 4'h0, 32'h0);
      chk("t1_data", mem_m[key(0, 32'h100)], 32'h1234_5678);

      // Byte strobes
      do_op(0, 1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF);
      do_op(0, 1'b1, 32'h40, 4'b0001, 32'h0000_00AA);
      do_op(0, 1'b1, 32'h40, 4'b0000, 32'h1111_1111);
      do_op(0, 1'b0, 32'h40, 4'h0, 32'h0);

      // Back-to-back reads at latency 1 give valid on consecutive cycles
      @(negedge clock);
      drive(0, 1'b0, 32'h100, 4'h0, 32'h0);
      @(negedge clock);
      chk("b2b_valid_a", 32'(valid[0]), 32'd1);
      chk("b2b_data_a", rdata[0], 32'h1234_5678);
      drive(0, 1'b0, 32'h40, 4'h0, 32'h0);
      @(negedge clock);
      idle(0);
      chk("b2b_valid_b", 32'(valid[0]), 32'd1);
      chk("b2b_data_b", rdata[0], 32'hFFFF_FFAA);
      chk("b2b_busy", 32'(busy[0]), 32'd0);

      // Latency 3 with a request held through the busy window
      do_op(1, 1'b1, 32'h500, 4'hF, 32'hCAFE_0001);
      do_op(1, 1'b1, 32'h504, 4'hF, 32'hCAFE_0002);
      @(negedge clock);
      drive(1, 1'b0, 32'h500, 4'h0, 32'h0);
      @(negedge clock);
      chk("hold_busy1", 32'(busy[1]), 32'd1);
      chk("hold_nv1", 32'(valid[1]), 32'd0);
      drive(1, 1'b0, 32'h504, 4'h0, 32'h0);
      @(negedge clock);
      chk("hold_busy2", 32'(busy[1]), 32'd1);
      chk("hold_nv2", 32'(valid[1]), 32'd0);
      @(negedge clock);
      chk("hold_valid_a", 32'(valid[1]), 32'd1);
      chk("hold_data_a", rdata[1], 32'hCAFE_0001);
      chk("hold_busy3", 32'(busy[1]), 32'd0);
      @(negedge clock);
      idle(1);
      chk("hold_busy4", 32'(busy[1]), 32'd1);
      chk("hold_nv4", 32'(valid[1]), 32'd0);
      @(negedge clock);
      chk("hold_busy5", 32'(busy[1]), 32'd1);
      @(negedge clock);
      chk("hold_valid_b", 32'(valid[1]), 32'd1);
      chk("hold_data_b", rdata[1], 32'hCAFE_0002);

      // LED write and counter deltas
      do_op(0, 1'b1, 32'hE000_0000, 4'hF, 32'h0000_00A5);
      chk("led_a5", led[0], 32'h0000_00A5);
      @(negedge clock);
      drive(0, 1'b0, 32'hE000_0004, 4'h0, 32'h0);
      @(negedge clock);
      idle(0);
      v1 = rdata[0];
      repeat (4) @(negedge clock);
      drive(0, 1'b0, 32'hE000_0004, 4'h0, 32'h0);
      @(negedge clock);
      idle(0);
      v2 = rdata[0];
      chk("counter_delta5", v2 - v1, 32'd5);
      do_op(0, 1'b1, 32'hE000_0004, 4'hF, 32'h0);

      // Unmapped access and status clear
      do_op(0, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
      chk("berr_set", 32'(berr[0]), 32'd1);
      do_op(0, 1'b0, 32'hE000_0008, 4'h0, 32'h0);
      do_op(0, 1'b1, 32'hE000_0008, 4'b0001, 32'h1);
      chk("berr_clr", 32'(berr[0]), 32'd0);
      do_op(1, 1'b1, 32'h0001_0000, 4'hF, 32'h1);
      do_op(1, 1'b0, 32'hE000_000C, 4'h0, 32'h0);

      // Randomized traffic against the reference model
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 60; i++) begin
            r  = int'($urandom_range(0, 9));
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            st = 4'($urandom);
            if (r < 5) begin
               a = 32'h200 + 32'($urandom_range(0, 7)) * 4;
               if (!mem_m.exists(key(s, a))) begin
                  w  = 1'b1;
                  st = 4'hF;
               end
            end else if (r < 8) begin
               case ($urandom_range(0, 4))
                  0: a = 32'hE000_0000;
                  1: a = 32'hE000_0004;
                  2: a = 32'hE000_0008;
                  3: a = 32'hE000_000C;
                  default: a = 32'hE000_0040;
               endcase
            end else begin
               case ($urandom_range(0, 2))
                  0: a = 32'h8000_0000;
                  1: a = 32'h0001_0000;
                  default: a = 32'hE001_0004;
               endcase
            end
            do_op(s, w, a, st, d);
         end
      end

      // Reset during a latency-3 read cancels it; RAM survives
      do_op(1, 1'b1, 32'h300, 4'hF, 32'h0BAD_F00D);
      do_op(1, 1'b1, 32'hE000_0000, 4'hF, 32'h55);
      do_op(1, 1'b0, 32'hC000_0000, 4'h0, 32'h0);
      @(negedge clock);
      drive(1, 1'b0, 32'h300, 4'h0, 32'h0);
      @(posedge clock);
      @(negedge clock);
      idle(1);
      resetn[1] = 1'b0;
      @(negedge clock);
      chk("mid_rst_valid", 32'(valid[1]), 32'd0);
      chk("mid_rst_busy", 32'(busy[1]), 32'd0);
      chk("mid_rst_led", led[1], 32'h0);
      chk("mid_rst_berr", 32'(berr[1]), 32'd0);
      resetn[1]   = 1'b1;
      led_m[1]    = 32'h0;
      berr_m[1]   = 1'b0;
      cnt_have[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("post_rst_nv", 32'(valid[1]), 32'd0);
         chk("post_rst_busy", 32'(busy[1]), 32'd0);
      end
      do_op(1, 1'b0, 32'h300, 4'h0, 32'h0);
      do_op(1, 1'b0, 32'h504, 4'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
